melee_hit_detector: RTL
=======================

// Module: melee_hit_detector
// PURPOSE
//  Consumer end of the melee swing offset: samples anim_x_offset each frame_tick and builds the weapon hitbox
//  from player position and facing. Tests it against the boss hitbox and issues exactly one damage pulse per swing.
//  Sits between the melee weapon animator and the boss HP / damage logic.
// PARAMETERS
//  WPN_W          32  weapon hitbox width, px (centred on tip_x)
//  WPN_H          16  weapon hitbox height, px (centred on char_y)
//  BOSS_HW        48  boss hitbox half-width, px
//  BOSS_HH        64  boss hitbox half-height, px
//  MIN_HIT_OFFSET 20  minimum offset at which the blade counts as striking
//  DAMAGE          5  damage value presented with each hit
// PORTS
//  clk            in   1   system clock
//  rst_n          in   1   synchronous reset, active low
//  frame_tick     in   1   one-clk pulse per video frame
//  alive          in   1   player alive
//  anim_x_offset  in   12  signed swing offset from animator; values <=0 mean no swing
//  char_x         in   12  player centre x, px, unsigned
//  char_y         in   12  player centre y, px, unsigned
//  flip_h         in   1   1 = player facing left
//  boss_x         in   12  boss centre x, px, unsigned
//  boss_y         in   12  boss centre y, px, unsigned
//  boss_alive     in   1   boss alive
//  hit_pulse      out  1   one-clk pulse: boss struck
//  hit_damage     out  8   DAMAGE while hit_pulse=1, else 0
//  swing_active   out  1   FSM in SWING or HIT_DONE
//  hit_count      out  8   total hits, saturates at 255
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): FSM=IDLE, pipeline valid bits cleared, all outputs 0. A pending pulse is dropped.
//  FSM advances only on frame_tick. Per tick, off = anim_x_offset treated as 0 if negative.
//   IDLE:     off>0 && alive -> SWING.
//   SWING:    off==0 || !alive -> IDLE. Else, if the hit pipeline reports overlap, go to HIT_DONE.
//   HIT_DONE: off==0 || !alive -> IDLE. No further hits until the FSM returns to IDLE.
//   An animator restart shows one frame of off==0, so the FSM passes through IDLE and a re-swing may hit again.
//  Hit pipeline (clk domain):
//   S0: on frame_tick, launch sample only if state(before update)==SWING, or IDLE with off>0, and off>=MIN_HIT_OFFSET.
//       Also requires alive && boss_alive.
//       Register tip_x = flip_h ? char_x-off : char_x+off, plus char_y, boss_x, boss_y.
//   S1: register the four-edge overlap test. Weapon box [tip_x-WPN_W/2, tip_x+WPN_W/2] x [char_y-WPN_H/2, char_y+WPN_H/2].
//       Boss box [boss_x-BOSS_HW, boss_x+BOSS_HW] x [boss_y-BOSS_HH, boss_y+BOSS_HH]. Edges inclusive.
//   S2: on overlap, drive hit_pulse=1 and hit_damage=DAMAGE for one clk, increment hit_count,
//       and tell the FSM to move SWING->HIT_DONE at the next frame_tick.
//  Latency: hit_pulse rises exactly 2 clk after the launching frame_tick.
//  At most one hit_pulse per swing, even if overlap persists.
//  Arithmetic: all box math in 14-bit signed, so tip_x/edges below 0 or above 4095 never wrap.
//  Negative coordinates are legal and simply fail to overlap on-screen targets.
//  frame_tick spacing is always >3 clk, so the pipeline never holds two samples.
//  Simultaneous events:
//   - boss_alive falling while a sample is in flight: the sample still completes. The gating uses the launch-time value.
//   - alive=0: blocks launch and forces IDLE, but an in-flight sample completes.
//   - hit_count at 255: stays 255 and hit_pulse still fires.
// TESTING
//  1. char(400,300), right, boss(480,300); off sequence 10,20,30,40,30,20,10,0 -> single hit_pulse
//     2 clk after the off=20 tick (tip 420, box 404..436 meets boss 432). hit_count=1, hit_damage=5 for that clk.
//  2. Same setup, flip_h=1 -> tip x 380..360, no overlap -> no hit_pulse. swing_active=1 during off>0, 0 after off=0.
//  3. Two swings separated by one off=0 frame, boss in range -> two hit_pulses, hit_count=2.
//  4. Offset peaking at 10 (<MIN_HIT_OFFSET) with boss overlapping -> no hit. boss_alive=0 with off=30 -> no hit.
//  5. char_x=5, flip_h=1, off=40 -> tip -35 (no wrap). Boss at x=4080 -> no hit.
//     rst_n low one clk after a launching frame_tick -> hit_pulse never asserts, all outputs 0.
//  6. Force hit_count to 255, one more hit -> hit_pulse=1 and hit_count stays 255.

Source files
------------

// File: rtl/melee_hit_detector.sv
// Melee hit detector: samples the swing offset each frame, builds the weapon hitbox and
// tests it against the boss hitbox. At most one damage pulse is issued per swing.
module melee_hit_detector #(
  parameter int WPN_W          = 32,
  parameter int WPN_H          = 16,
  parameter int BOSS_HW        = 48,
  parameter int BOSS_HH        = 64,
  parameter int MIN_HIT_OFFSET = 20,
  parameter int DAMAGE         = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        alive,
  input  logic [11:0] anim_x_offset,
  input  logic [11:0] char_x,
  input  logic [11:0] char_y,
  input  logic        flip_h,
  input  logic [11:0] boss_x,
  input  logic [11:0] boss_y,
  input  logic        boss_alive,
  output logic        hit_pulse,
  output logic [7:0]  hit_damage,
  output logic        swing_active,
  output logic [7:0]  hit_count
);

  typedef enum logic [1:0] {IDLE, SWING, HIT_DONE} state_t;

  localparam logic [11:0]        MIN_OFF = 12'(MIN_HIT_OFFSET);
  localparam logic signed [13:0] WHW     = 14'(WPN_W / 2);
  localparam logic signed [13:0] WHH     = 14'(WPN_H / 2);
  localparam logic signed [13:0] BHW     = 14'(BOSS_HW);
  localparam logic signed [13:0] BHH     = 14'(BOSS_HH);
  localparam logic [7:0]         DMG     = 8'(DAMAGE);

  state_t state, state_nx;
  logic [11:0] off;
  logic        launch;
  logic        swing_hit;

  logic               s0_v;
  logic signed [13:0] s0_tip, s0_cy, s0_bx, s0_by, tip_nx;
  logic               overlap;
  logic               s1_hit;

  always_comb begin
    off    = anim_x_offset[11] ? '0 : anim_x_offset;
    launch = frame_tick && alive && boss_alive && (off >= MIN_OFF) &&
             ((state == SWING) || ((state == IDLE) && (off != '0)));
    tip_nx = flip_h ? ($signed({2'b00, char_x}) - $signed({2'b00, off}))
                    : ($signed({2'b00, char_x}) + $signed({2'b00, off}));
  end

  always_comb begin
    overlap = ((s0_tip - WHW) <= (s0_bx + BHW)) &&
              ((s0_tip + WHW) >= (s0_bx - BHW)) &&
              ((s0_cy  - WHH) <= (s0_by + BHH)) &&
              ((s0_cy  + WHH) >= (s0_by - BHH));
  end

  always_comb begin
    state_nx = state;
    if (frame_tick) begin
      case (state)
        IDLE:     if (off != '0 && alive) state_nx = SWING;
        SWING:    if (off == '0 || !alive) state_nx = IDLE;
                  else if (swing_hit)      state_nx = HIT_DONE;
        HIT_DONE: if (off == '0 || !alive) state_nx = IDLE;
        default:  state_nx = IDLE;
      endcase
    end
    swing_active = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0_v   <= 1'b0;
      s0_tip <= '0;
      s0_cy  <= '0;
      s0_bx  <= '0;
      s0_by  <= '0;
      s1_hit <= 1'b0;
    end else begin
      s0_v <= launch;
      if (launch) begin
        s0_tip <= tip_nx;
        s0_cy  <= $signed({2'b00, char_y});
        s0_bx  <= $signed({2'b00, boss_x});
        s0_by  <= $signed({2'b00, boss_y});
      end
      s1_hit <= s0_v && overlap;
    end
  end

  // Samples keep launching while SWING waits for the next tick; swing_hit
  // suppresses any follow-up pulse until the FSM has passed through IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_pulse  <= 1'b0;
      hit_damage <= '0;
      hit_count  <= '0;
      swing_hit  <= 1'b0;
    end else begin
      hit_pulse  <= 1'b0;
      hit_damage <= '0;
      if (state == IDLE) swing_hit <= 1'b0;
      if (s1_hit && !swing_hit) begin
        hit_pulse  <= 1'b1;
        hit_damage <= DMG;
        swing_hit  <= 1'b1;
        if (hit_count != '1) hit_count <= hit_count + 8'd1;
      end
    end
  end

endmodule
